mine_placer: RTL



---
 rtl/game_pkg.sv | 36 +++
 rtl/lfsr_gen.sv | 24 ++
 rtl/mine_placer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants, state encoding and coordinate/count types.
package game_pkg;

  localparam int unsigned MAX_DIM   = 16;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned DIM_W     = 5;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned AREA_W    = 10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,15,13,4 expressed as bit positions 15,14,12,3
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    CHECK,
    FINISH
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   count_t;
  typedef logic [DIM_W-1:0]   dim_t;

  // Limit the mine request to the cells available on a dim x dim board.
  function automatic count_t clamp_target(input dim_t dim, input count_t mines, input logic safe);
    logic [AREA_W-1:0] area;
    logic [AREA_W-1:0] limit;
    area  = AREA_W'(dim) * AREA_W'(dim);
    limit = area - AREA_W'(safe);
    return (AREA_W'(mines) <= limit) ? mines : CNT_W'(limit);
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR; shifts left, feedback is the XOR of the tapped bits.
module lfsr_gen #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(16'hD008)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] value
);

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Fills an N x N mine bitmap with distinct pseudo-random cells after a level is latched.
// Optional MINE_PLACER_SAFE_CELL_EN adds safe_x/safe_y: one cell that is never mined.
module mine_placer #(
  parameter int unsigned          MAX_DIM   = game_pkg::MAX_DIM,
  parameter int unsigned          LFSR_W    = game_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0]    LFSR_SEED = LFSR_W'(game_pkg::LFSR_SEED)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [4:0]                   button_num,
  input  logic [5:0]                   mines,
  output logic                         busy,
  output logic                         done,
  output logic [MAX_DIM*MAX_DIM-1:0]   mine_map,
  output logic [5:0]                   placed_cnt
`ifdef MINE_PLACER_SAFE_CELL_EN
  ,
  input  logic [3:0]                   safe_x,
  input  logic [3:0]                   safe_y
`endif
);

  import game_pkg::*;

  localparam int unsigned MAP_W = MAX_DIM * MAX_DIM;
  localparam int unsigned IDX_W = $clog2(MAP_W);

`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam logic SAFE = 1'b1;
`else
  localparam logic SAFE = 1'b0;
`endif

  state_t             state_q, state_d;
  dim_t               dim_q, dim_d;
  count_t             target_q, target_d;
  coord_t             cx_q, cx_d;
  coord_t             cy_q, cy_d;
  logic               busy_d;
  logic               done_d;
  logic [MAP_W-1:0]   map_d;
  count_t             cnt_d;
  logic [LFSR_W-1:0]  lfsr;
  logic [IDX_W-1:0]   cell_idx;
  logic               reject;
  logic               lfsr_unused;

`ifdef MINE_PLACER_SAFE_CELL_EN
  coord_t             sx_q, sx_d;
  coord_t             sy_q, sy_d;
  logic               is_safe;
  assign is_safe = (cx_q == sx_q) && (cy_q == sy_q);
`else
  logic               is_safe;
  assign is_safe = 1'b0;
`endif

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  // Only the low byte feeds the candidate coordinates.
  assign lfsr_unused = ^lfsr[LFSR_W-1:8];

  assign cell_idx = IDX_W'(cy_q) * IDX_W'(MAX_DIM) + IDX_W'(cx_q);
  assign reject   = (DIM_W'(cx_q) >= dim_q) || (DIM_W'(cy_q) >= dim_q) ||
                    mine_map[cell_idx] || is_safe;

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    dim_d    = dim_q;
    target_d = target_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    busy_d   = busy;
    done_d   = 1'b0;
    map_d    = mine_map;
    cnt_d    = placed_cnt;
`ifdef MINE_PLACER_SAFE_CELL_EN
    sx_d     = sx_q;
    sy_d     = sy_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dim_d    = button_num;
          target_d = clamp_target(button_num, mines, SAFE);
`ifdef MINE_PLACER_SAFE_CELL_EN
          sx_d     = safe_x;
          sy_d     = safe_y;
`endif
          busy_d   = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        map_d  = '0;
        cnt_d  = '0;
        busy_d = 1'b1;
        if ((dim_q == '0) || (target_q == '0) || (32'(dim_q) > MAX_DIM)) begin
          state_d = FINISH;
        end else begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        cx_d    = lfsr[3:0];
        cy_d    = lfsr[7:4];
        state_d = CHECK;
      end
      CHECK: begin
        if (reject) begin
          state_d = DRAW;
        end else begin
          map_d[cell_idx] = 1'b1;
          cnt_d           = placed_cnt + 6'd1;
          state_d         = ((placed_cnt + 6'd1) == target_q) ? FINISH : DRAW;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dim_q      <= '0;
      target_q   <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mine_map   <= '0;
      placed_cnt <= '0;
`ifdef MINE_PLACER_SAFE_CELL_EN
      sx_q       <= '0;
      sy_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      target_q   <= target_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      busy       <= busy_d;
      done       <= done_d;
      mine_map   <= map_d;
      placed_cnt <= cnt_d;
`ifdef MINE_PLACER_SAFE_CELL_EN
      sx_q       <= sx_d;
      sy_q       <= sy_d;
`endif
    end
  end

endmodule
